instr_fetch_router: RTL and testbench
=====================================

// Module: instr_fetch_router
// PURPOSE
// Routes the Ibex instruction-fetch port to NrRegions fetchable memories (RAM, debug ROM, boot ROM, ...)
// by base/mask address decode, with in-order tracking of up to MaxOutstanding fetches and an error
// response for unmapped addresses. Sits between ibex_top instr_* and the memory instruction ports.
// PARAMETERS
// NrRegions       2   number of fetchable regions; index 0 has highest decode priority
// AddrWidth       32  fetch address width
// DataWidth       32  fetch data width
// MaxOutstanding  2   maximum in-flight fetches (response FIFO depth, >=1)
// PORTS
// clk_sys_i          in   1                    system clock
// rst_sys_ni         in   1                    asynchronous active-low reset
// host_req_i         in   1                    fetch request from core
// host_addr_i        in   AddrWidth            fetch address, held stable while req && !gnt
// host_gnt_o         out  1                    request accepted this cycle
// host_rvalid_o      out  1                    response valid
// host_rdata_o       out  DataWidth            response data (0 on error)
// host_err_o         out  1                    response is a bus error
// cfg_region_base_i  in   NrRegions x AddrWidth region base addresses
// cfg_region_mask_i  in   NrRegions x AddrWidth region masks
// dev_req_o          out  NrRegions            per-region fetch request
// dev_addr_o         out  AddrWidth            shared fetch address (host_addr_i)
// dev_gnt_i          in   NrRegions            region accepts (0 = busy, e.g. shared with data bus)
// dev_rvalid_i       in   NrRegions            per-region response valid
// dev_rdata_i        in   NrRegions x DataWidth per-region response data
// dev_err_i          in   NrRegions            per-region error
// stray_rvalid_o     out  1                    pulse: dev_rvalid_i seen for a region not at FIFO head
// perf_fetch_o       out  32                   accepted-fetch count (FETCH_ROUTER_PERF_EN)
// perf_stall_o       out  32                   stalled-request cycle count (FETCH_ROUTER_PERF_EN)
// BEHAVIOUR
// - Reset: FIFO empty; host_gnt_o/host_rvalid_o/host_err_o/stray_rvalid_o=0, host_rdata_o=0, perf counters 0.
// - Decode (comb): hit[i] = (host_addr_i & mask[i]) == base[i]; lowest hit index wins; no hit = unmapped.
// - space = FIFO not full, or full with head completing this cycle (host_rvalid_o=1).
// - dev_req_o[sel] = host_req_i & space & mapped; all other bits 0.
// - host_gnt_o = host_req_i & space & (unmapped | dev_gnt_i[sel]); same cycle as request (0-cycle grant).
// - On grant: push tag (sel, or UnmappedTag=NrRegions) into FIFO.
// - Response: head tag h; regions: host_rvalid_o = dev_rvalid_i[h], rdata = dev_rdata_i[h], err = dev_err_i[h].
//   Unmapped head: host_rvalid_o=1, host_err_o=1, rdata=0 in the first cycle it is head (>=1 cycle after grant).
// - Pop on host_rvalid_o. Simultaneous push+pop keeps count; responses strictly in grant order.
// - dev_rvalid_i[j] with FIFO empty or j != h: dropped, stray_rvalid_o=1 for one cycle.
// - FIFO full and head not completing: host_gnt_o=0, dev_req_o=0; core holds request.
// - Reset mid-operation clears FIFO; late device responses after reset are reported as stray.
// - Widths: FIFO count is $clog2(MaxOutstanding+1) bits; tag is $clog2(NrRegions+1) bits.
// CONFIGURATION
// - `FETCH_ROUTER_PERF_EN defined: perf_fetch_o increments per host_gnt_o; perf_stall_o increments per
//   cycle with host_req_i & !host_gnt_o; both saturate at 32'hFFFF_FFFF.
// - Not defined: perf_fetch_o/perf_stall_o tied to 0, no counter flops.
// STRUCTURE
// - fetch_router_pkg: tag width function, UnmappedTag constant, region_tag_t typedef.
// - Sub-module fetch_router_resp_fifo: synchronous tag FIFO, depth MaxOutstanding, push/pop/full/empty/head.
// - Top: decode, grant logic, response mux, stray detection, optional perf counters.
// TESTING
// - RAM base 0x0010_0000 mask 0xFFFF_0000, fetch 0x0010_0080 -> gnt same cycle, dev_req_o=01, rvalid data returned.
// - Fetch 0x9000_0000 (unmapped) -> gnt same cycle, next cycle rvalid=1 err=1 rdata=0.
// - Debug region dev_gnt_i[1]=0 for 3 cycles -> gnt held 0, perf_stall_o=3, grant on 4th cycle.
// - MaxOutstanding=2, RAM delays rvalid: 2 grants, 3rd blocked until 1st response, order RAM,RAM.
// - Overlapping regions 0 and 1 both hit 0x1A11_0000 -> dev_req_o=01 (index 0 priority).
// - Inject dev_rvalid_i[1] with FIFO empty -> stray_rvalid_o=1 one cycle, host_rvalid_o=0.

Source files
------------

// File: rtl/fetch_router_pkg.sv
// Shared types and helpers for the instruction-fetch router.
// A response tag names the region that owns an in-flight fetch. The extra
// value UnmappedTag marks a fetch to an address that no region decodes.
package fetch_router_pkg;

    // Tag width able to encode every region index plus the unmapped marker.
    function automatic int unsigned tag_width(input int unsigned nr_regions);
        return (nr_regions < 1) ? 1 : $clog2(nr_regions + 1);
    endfunction

    // Width of an occupancy counter that must reach 'depth' itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Tag type and unmapped marker for the default two-region configuration.
    localparam int unsigned NrRegionsDefault = 2;
    localparam int unsigned TagWidth         = tag_width(NrRegionsDefault);

    typedef logic [TagWidth-1:0] region_tag_t;

    localparam region_tag_t UnmappedTag = region_tag_t'(NrRegionsDefault);

endpackage

// File: rtl/fetch_router_resp_fifo.sv
// In-order tag FIFO for the fetch router. It records which region owns each
// granted fetch so responses are matched strictly in grant order.
// A push and a pop in the same cycle leave the occupancy unchanged, which
// lets a full FIFO accept a new fetch while its head completes.
module fetch_router_resp_fifo
    import fetch_router_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic             push,
    input  logic [Width-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head_tag
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = count_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;

    // Circular pointer advance that also handles non-power-of-two depths.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Pointer and occupancy tracking; only these need a defined reset value.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage written on push.
    // NOTE: storage is not reset; contents are only observed through 'empty'-qualified head_tag.
    always_ff @(posedge clk_sys_i) begin
        if (push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    assign full     = (count == CntW'(Depth));
    assign empty    = (count == '0);
    assign head_tag = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_router.sv
// Instruction-fetch router: decodes the core fetch address against
// base/mask regions, grants in the same cycle, tracks in-flight fetches in
// grant order and returns an error response for unmapped addresses.
// Optional feature: define FETCH_ROUTER_PERF_EN to build the saturating
// accepted-fetch and stalled-cycle counters; otherwise both read as zero.
module instr_fetch_router
    import fetch_router_pkg::*;
#(
    parameter int NrRegions      = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                 clk_sys_i,
    input  logic                                 rst_sys_ni,
    input  logic                                 host_req_i,
    input  logic [AddrWidth-1:0]                 host_addr_i,
    output logic                                 host_gnt_o,
    output logic                                 host_rvalid_o,
    output logic [DataWidth-1:0]                 host_rdata_o,
    output logic                                 host_err_o,
    input  logic [NrRegions-1:0][AddrWidth-1:0]  cfg_region_base_i,
    input  logic [NrRegions-1:0][AddrWidth-1:0]  cfg_region_mask_i,
    output logic [NrRegions-1:0]                 dev_req_o,
    output logic [AddrWidth-1:0]                 dev_addr_o,
    input  logic [NrRegions-1:0]                 dev_gnt_i,
    input  logic [NrRegions-1:0]                 dev_rvalid_i,
    input  logic [NrRegions-1:0][DataWidth-1:0]  dev_rdata_i,
    input  logic [NrRegions-1:0]                 dev_err_i,
    output logic                                 stray_rvalid_o,
    output logic [31:0]                          perf_fetch_o,
    output logic [31:0]                          perf_stall_o
);

    localparam int unsigned TagW = tag_width(NrRegions);
    localparam logic [TagW-1:0] TagUnmapped = TagW'(NrRegions);

    logic                 mapped;
    logic [TagW-1:0]      sel_tag;
    logic                 sel_gnt;
    logic [NrRegions-1:0] sel_onehot;
    logic                 space;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [TagW-1:0]      head_tag;
    logic [TagW-1:0]      push_tag;

    // Address decode: scan from the highest index down so the lowest hit wins.
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        mapped     = 1'b0;
        sel_tag    = TagUnmapped;
        sel_gnt    = 1'b0;
        sel_onehot = '0;
        for (int i = NrRegions - 1; i >= 0; i--) begin
            if ((host_addr_i & cfg_region_mask_i[i]) == cfg_region_base_i[i]) begin
                mapped        = 1'b1;
                sel_tag       = TagW'(i);
                sel_gnt       = dev_gnt_i[i];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // A full FIFO still accepts when its head retires this same cycle.
    assign space      = !fifo_full || host_rvalid_o;
    assign host_gnt_o = host_req_i && space && (!mapped || sel_gnt);
    assign dev_req_o  = (host_req_i && space && mapped) ? sel_onehot : '0;
    assign dev_addr_o = host_addr_i;
    assign push_tag   = mapped ? sel_tag : TagUnmapped;

    fetch_router_resp_fifo #(
        .Depth (MaxOutstanding),
        .Width (TagW)
    ) u_resp_fifo (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .push       (host_gnt_o),
        .push_tag   (push_tag),
        .pop        (host_rvalid_o),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_tag   (head_tag)
    );

    // Response mux from the head region; responses from any other region are dropped as stray.
    always_comb begin
        host_rvalid_o  = 1'b0;
        host_rdata_o   = '0;
        host_err_o     = 1'b0;
        stray_rvalid_o = 1'b0;
        if (!fifo_empty && head_tag == TagUnmapped) begin
            host_rvalid_o = 1'b1;
            host_err_o    = 1'b1;
        end
        for (int i = 0; i < NrRegions; i++) begin
            if (!fifo_empty && head_tag == TagW'(i)) begin
                host_rvalid_o = dev_rvalid_i[i];
                host_rdata_o  = dev_rdata_i[i];
                host_err_o    = dev_err_i[i];
            end else if (dev_rvalid_i[i]) begin
                stray_rvalid_o = 1'b1;
            end
        end
    end

`ifdef FETCH_ROUTER_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Saturating counters of accepted fetches and cycles a request waits ungranted.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (host_gnt_o && fetch_cnt != '1) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (host_req_i && !host_gnt_o && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_o = fetch_cnt;
    assign perf_stall_o = stall_cnt;
`else
    assign perf_fetch_o = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_router.sv
// Directed bench for instr_fetch_router: a table of single-cycle decode/grant
// vectors plus hand-written multi-cycle sequences for responses, stalls,
// back-pressure, priority, stray responses and reset mid-operation.
module tb_instr_fetch_router;

`ifdef FETCH_ROUTER_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic [31:0]      addr;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             err;
    logic [1:0][31:0] base;
    logic [1:0][31:0] mask;
    logic [1:0]       dreq;
    logic [31:0]      daddr;
    logic [1:0]       dgnt;
    logic [1:0]       drv;
    logic [1:0][31:0] drdata;
    logic [1:0]       derr;
    logic             stray;
    logic [31:0]      pfetch;
    logic [31:0]      pstall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_router dut (
        .clk_sys_i         (clk),
        .rst_sys_ni        (rst_n),
        .host_req_i        (req),
        .host_addr_i       (addr),
        .host_gnt_o        (gnt),
        .host_rvalid_o     (rvalid),
        .host_rdata_o      (rdata),
        .host_err_o        (err),
        .cfg_region_base_i (base),
        .cfg_region_mask_i (mask),
        .dev_req_o         (dreq),
        .dev_addr_o        (daddr),
        .dev_gnt_i         (dgnt),
        .dev_rvalid_i      (drv),
        .dev_rdata_i       (drdata),
        .dev_err_i         (derr),
        .stray_rvalid_o    (stray),
        .perf_fetch_o      (pfetch),
        .perf_stall_o      (pstall)
    );

    typedef struct {
        logic [31:0] addr;
        logic        req;
        logic [1:0]  dgnt;
        logic        exp_gnt;
        logic [1:0]  exp_dreq;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_perf(input string name, input logic [31:0] exp_fetch, input logic [31:0] exp_stall);
        check({name, "_perf_fetch"}, pfetch, PerfEn ? exp_fetch : 32'd0);
        check({name, "_perf_stall"}, pstall, PerfEn ? exp_stall : 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 1'b0;
        addr   = '0;
        dgnt   = 2'b11;
        drv    = 2'b00;
        drdata = '0;
        derr   = 2'b00;
        base[0] = 32'h0010_0000; mask[0] = 32'hFFFF_0000;
        base[1] = 32'h1A11_0000; mask[1] = 32'hFFFF_0000;

        //            addr          req   dgnt   gnt   dreq
        vecs[0] = '{32'h0010_0080, 1'b1, 2'b11, 1'b1, 2'b01};
        vecs[1] = '{32'h1A11_0004, 1'b1, 2'b11, 1'b1, 2'b10};
        vecs[2] = '{32'h1A11_0004, 1'b1, 2'b01, 1'b0, 2'b10};
        vecs[3] = '{32'h0010_FFFC, 1'b1, 2'b10, 1'b0, 2'b01};
        vecs[4] = '{32'h9000_0000, 1'b1, 2'b00, 1'b1, 2'b00};
        vecs[5] = '{32'h0011_0000, 1'b1, 2'b11, 1'b1, 2'b00};
        vecs[6] = '{32'h0010_0080, 1'b0, 2'b11, 1'b0, 2'b00};
        vecs[7] = '{32'h000F_FFFC, 1'b1, 2'b11, 1'b1, 2'b00};

        // Reset state
        repeat (2) cyc();
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_stray", stray, 0);
        check("rst_dreq", dreq, 0);
        check_perf("rst", 0, 0);
        cyc();
        rst_n = 1'b1;

        // Decode/grant table; the request is dropped before the rising edge so nothing is pushed.
        for (int i = 0; i < 8; i++) begin
            cyc();
            req  = vecs[i].req;
            addr = vecs[i].addr;
            dgnt = vecs[i].dgnt;
            #1;
            check($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
            check($sformatf("vec%0d_dreq", i), dreq, vecs[i].exp_dreq);
            check($sformatf("vec%0d_daddr", i), daddr, vecs[i].addr);
            check($sformatf("vec%0d_rvalid", i), rvalid, 0);
            req = 1'b0;
        end
        dgnt = 2'b11;
        cyc(); #1;
        check_perf("table", 0, 0);

        // RAM fetch with a one-cycle device response
        req = 1'b1; addr = 32'h0010_0080;
        #1;
        check("ram_gnt", gnt, 1);
        check("ram_dreq", dreq, 2'b01);
        cyc();
        req = 1'b0; drv = 2'b01; drdata[0] = 32'hDEAD_BEEF;
        #1;
        check("ram_rvalid", rvalid, 1);
        check("ram_rdata", rdata, 32'hDEAD_BEEF);
        check("ram_err", err, 0);
        check("ram_stray", stray, 0);
        cyc();
        drv = 2'b00;
        #1;
        check("ram_idle", rvalid, 0);

        // Unmapped fetch: same-cycle grant, error response next cycle
        req = 1'b1; addr = 32'h9000_0000;
        #1;
        check("unm_gnt", gnt, 1);
        check("unm_dreq", dreq, 2'b00);
        check("unm_rvalid_early", rvalid, 0);
        cyc();
        req = 1'b0;
        #1;
        check("unm_rvalid", rvalid, 1);
        check("unm_err", err, 1);
        check("unm_rdata", rdata, 0);
        cyc(); #1;
        check("unm_idle", rvalid, 0);

        // Debug region busy for three cycles
        req = 1'b1; addr = 32'h1A11_0000; dgnt = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_gnt", i), gnt, 0);
            check($sformatf("stall%0d_dreq", i), dreq, 2'b10);
            cyc();
        end
        dgnt = 2'b11;
        #1;
        check("stall_gnt4", gnt, 1);
        check_perf("stall", 2, 3);
        cyc();
        req = 1'b0; drv = 2'b10; drdata[1] = 32'h1234_5678;
        #1;
        check("dbg_rvalid", rvalid, 1);
        check("dbg_rdata", rdata, 32'h1234_5678);
        cyc();
        drv = 2'b00;

        // Two outstanding fetches fill the FIFO; the third waits for the first response
        req = 1'b1; addr = 32'h0010_0000;
        #1;
        check("out1_gnt", gnt, 1);
        cyc();
        addr = 32'h0010_0004;
        #1;
        check("out2_gnt", gnt, 1);
        check("out2_rvalid", rvalid, 0);
        cyc();
        addr = 32'h0010_0008;
        #1;
        check("out3_blocked_gnt", gnt, 0);
        check("out3_blocked_dreq", dreq, 2'b00);
        cyc();
        drv = 2'b01; drdata[0] = 32'hA000_0001;
        #1;
        check("out3_gnt", gnt, 1);
        check("out3_dreq", dreq, 2'b01);
        check("resp1_rvalid", rvalid, 1);
        check("resp1_rdata", rdata, 32'hA000_0001);
        cyc();
        req = 1'b0; drdata[0] = 32'hA000_0002;
        #1;
        check("resp2_rvalid", rvalid, 1);
        check("resp2_rdata", rdata, 32'hA000_0002);
        cyc();
        drdata[0] = 32'hA000_0003;
        #1;
        check("resp3_rvalid", rvalid, 1);
        check("resp3_rdata", rdata, 32'hA000_0003);
        cyc();
        drv = 2'b00;
        #1;
        check("out_drained", rvalid, 0);
        check_perf("outstanding", 6, 4);

        // Overlapping regions: index 0 wins
        base[0] = 32'h1A00_0000; mask[0] = 32'hFF00_0000;
        req = 1'b1; addr = 32'h1A11_0000;
        #1;
        check("overlap_dreq", dreq, 2'b01);
        check("overlap_gnt", gnt, 1);
        req = 1'b0;
        base[0] = 32'h0010_0000; mask[0] = 32'hFFFF_0000;
        cyc();

        // Stray responses: FIFO empty, then head owned by another region
        drv = 2'b10; drdata[1] = 32'hBAD0_0001;
        #1;
        check("stray_empty", stray, 1);
        check("stray_empty_rvalid", rvalid, 0);
        cyc();
        drv = 2'b00;
        #1;
        check("stray_pulse_end", stray, 0);
        req = 1'b1; addr = 32'h0010_0040;
        #1;
        check("stray_ram_gnt", gnt, 1);
        cyc();
        req = 1'b0; drv = 2'b10;
        #1;
        check("stray_wrong_region", stray, 1);
        check("stray_wrong_rvalid", rvalid, 0);
        cyc();
        drv = 2'b01; drdata[0] = 32'h5555_AAAA;
        #1;
        check("stray_head_rvalid", rvalid, 1);
        check("stray_head_rdata", rdata, 32'h5555_AAAA);
        check("stray_head_clear", stray, 0);
        cyc();
        drv = 2'b00;
        #1;
        check_perf("final", 7, 4);

        // Reset while a fetch is in flight; the late response becomes stray
        req = 1'b1; addr = 32'h0010_0000;
        #1;
        check("rst_mid_gnt", gnt, 1);
        cyc();
        req = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        check_perf("rst_mid", 0, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        drv = 2'b01; drdata[0] = 32'hC0FF_EE00;
        #1;
        check("late_stray", stray, 1);
        check("late_rvalid", rvalid, 0);
        cyc();
        drv = 2'b00;
        #1;
        check("late_stray_end", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
